// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory bus between two cache requesters (port 0 = icache,
//   port 1 = dcache). Only one transaction is outstanding at a time, and a
//   tie goes to the port that was not granted last (round-robin). The winning
//   request is latched onto the mem_* outputs. After MEM_LATENCY cycles the
//   read data is captured, and the winner receives a one-cycle ready pulse.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   reqN_valid                   request from port N; held until ready is seen
//   reqN_address                 word address for port N
//   reqN_write_data              store data for port N
//   reqN_write_enable            1 = write, 0 = read
//   reqN_ready                   one-cycle completion pulse to port N
//   reqN_read_data               last read result for port N
//   mem_address/mem_write_data   memory bus address and store data
//   mem_write_enable             write strobe, first BUSY cycle of a write only
//   mem_read_data                memory bus read data
//   busy                         high while a transaction is in BUSY or RESP
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_write_data,
  input  logic              req0_write_enable,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_read_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_write_data,
  input  logic              req1_write_enable,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_read_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter only has to hold MEM_LATENCY-1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic              last_grant_r;
  logic              winner_r;
  logic              txn_write_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              grant_s;
  logic              grant_port_s;
  logic [ADDR_W-1:0] sel_address_s;
  logic [DATA_W-1:0] sel_write_data_s;
  logic              sel_write_enable_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and grant decision. On a tie the port that did not win last
  // time is chosen, so a waiting port is never starved.
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    grant_port_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_s      = 1'b1;
          grant_port_s = ~last_grant_r;
        end else if (req0_valid) begin
          grant_s      = 1'b1;
          grant_port_s = 1'b0;
        end else if (req1_valid) begin
          grant_s      = 1'b1;
          grant_port_s = 1'b1;
        end else begin
          grant_s      = 1'b0;
          grant_port_s = 1'b0;
        end
        if (grant_s) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == '0) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Route the request fields of the port that would be granted.
  always_comb begin
    sel_address_s      = req0_address;
    sel_write_data_s   = req0_write_data;
    sel_write_enable_s = req0_write_enable;
    if (grant_port_s) begin
      sel_address_s      = req1_address;
      sel_write_data_s   = req1_write_data;
      sel_write_enable_s = req1_write_enable;
    end else begin
      sel_address_s      = req0_address;
      sel_write_data_s   = req0_write_data;
      sel_write_enable_s = req0_write_enable;
    end
  end

  // Bus drive, latency counting, read capture and the ready pulse. The write
  // strobe and the ready pulses default low, so each is high for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r     <= 1'b1;
      winner_r         <= 1'b0;
      txn_write_r      <= 1'b0;
      cnt_r            <= '0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      req0_ready       <= 1'b0;
      req1_ready       <= 1'b0;
      req0_read_data   <= '0;
      req1_read_data   <= '0;
      busy             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      req0_ready       <= 1'b0;
      req1_ready       <= 1'b0;
      busy             <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            winner_r         <= grant_port_s;
            last_grant_r     <= grant_port_s;
            txn_write_r      <= sel_write_enable_s;
            cnt_r            <= CNT_LOAD;
            mem_address      <= sel_address_s;
            mem_write_data   <= sel_write_data_s;
            mem_write_enable <= sel_write_enable_s;
          end
        end
        BUSY: begin
          if (cnt_r == '0) begin
            // Writes leave the read-data register of the winner untouched.
            if (!txn_write_r) begin
              if (winner_r) begin
                req1_read_data <= mem_read_data;
              end else begin
                req0_read_data <= mem_read_data;
              end
            end
            if (winner_r) begin
              req1_ready <= 1'b1;
            end else begin
              req0_ready <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench. dut_a runs with MEM_LATENCY=2 and dut_b with
//   MEM_LATENCY=1, and the two share their request inputs. Inputs are driven
//   and outputs sampled on the falling edge. The memory returns 0xDEADBEEF
//   for address 0x100 and address ^ 0xA5A50000 for any other address.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_write_enable, req1_valid, req1_write_enable;
  logic [31:0] req0_address, req0_write_data, req1_address, req1_write_data;

  logic        a_req0_ready, a_req1_ready, a_mem_write_enable, a_busy;
  logic [31:0] a_req0_read_data, a_req1_read_data, a_mem_address, a_mem_write_data, a_mem_read_data;
  logic        b_req0_ready, b_req1_ready, b_mem_write_enable, b_busy;
  logic [31:0] b_req0_read_data, b_req1_read_data, b_mem_address, b_mem_write_data, b_mem_read_data;

  int checks   = 0;
  int failures = 0;
  logic        mid_raise = 1'b0;
  logic [31:0] mid_addr  = 32'h0;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
    else return addr ^ 32'hA5A5_0000;
  endfunction

  assign a_mem_read_data = mem_model(a_mem_address);
  assign b_mem_read_data = mem_model(b_mem_address);

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_write_data(req0_write_data),
    .req0_write_enable(req0_write_enable), .req0_ready(a_req0_ready), .req0_read_data(a_req0_read_data),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_write_data(req1_write_data),
    .req1_write_enable(req1_write_enable), .req1_ready(a_req1_ready), .req1_read_data(a_req1_read_data),
    .mem_address(a_mem_address), .mem_write_data(a_mem_write_data),
    .mem_write_enable(a_mem_write_enable), .mem_read_data(a_mem_read_data), .busy(a_busy)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_write_data(req0_write_data),
    .req0_write_enable(req0_write_enable), .req0_ready(b_req0_ready), .req0_read_data(b_req0_read_data),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_write_data(req1_write_data),
    .req1_write_enable(req1_write_enable), .req1_ready(b_req1_ready), .req1_read_data(b_req1_read_data),
    .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
    .mem_write_enable(b_mem_write_enable), .mem_read_data(b_mem_read_data), .busy(b_busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic a_ready(input int port);
    return (port == 0) ? a_req0_ready : a_req1_ready;
  endfunction

  // Called at a falling edge with the request already driven; a grant is
  // expected at the next rising edge. Returns at the falling edge where the
  // ready pulse is visible.
  task automatic expect_txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic is_write, input logic [31:0] rdata);
    int n;
    int we_cycles;
    @(negedge clk);
    check_eq("grant_addr", a_mem_address, addr);
    check_eq("busy_on", 32'(a_busy), 32'd1);
    if (is_write) check_eq("grant_wdata", a_mem_write_data, wdata);
    we_cycles = a_mem_write_enable ? 1 : 0;
    if (mid_raise) begin
      req1_valid        = 1'b1;
      req1_address      = mid_addr;
      req1_write_enable = 1'b0;
      mid_raise         = 1'b0;
    end
    n = 0;
    while (!a_ready(port) && n < 8) begin
      @(negedge clk);
      n++;
      if (a_mem_write_enable) we_cycles++;
    end
    check_eq("ready_latency", 32'(n), 32'd2);
    check_eq("addr_hold", a_mem_address, addr);
    check_eq("we_cycles", 32'(we_cycles), is_write ? 32'd1 : 32'd0);
    check_eq("other_ready", 32'((port == 0) ? a_req1_ready : a_req0_ready), 32'd0);
    check_eq("read_data", (port == 0) ? a_req0_read_data : a_req1_read_data, rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    req0_valid = 1'b0; req0_address = 32'h0; req0_write_data = 32'h0; req0_write_enable = 1'b0;
    req1_valid = 1'b0; req1_address = 32'h0; req1_write_data = 32'h0; req1_write_enable = 1'b0;

    // Reset state of both instances.
    do_reset();
    check_eq("rst_a_addr", a_mem_address, 32'h0);
    check_eq("rst_a_we", 32'(a_mem_write_enable), 32'd0);
    check_eq("rst_a_busy", 32'(a_busy), 32'd0);
    check_eq("rst_a_ready", 32'({a_req0_ready, a_req1_ready}), 32'd0);
    check_eq("rst_a_rd0", a_req0_read_data, 32'h0);
    check_eq("rst_b_busy", 32'(b_busy), 32'd0);
    check_eq("rst_b_ready", 32'({b_req0_ready, b_req1_ready}), 32'd0);

    // Test 1: single port 0 read of 0x100.
    req0_valid = 1'b1; req0_address = 32'h100; req0_write_enable = 1'b0;
    expect_txn(0, 32'h100, 32'h0, 1'b0, 32'hDEAD_BEEF);
    check_eq("t1_busy_resp", 32'(a_busy), 32'd1);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_ready_drop", 32'(a_req0_ready), 32'd0);
    check_eq("t1_busy_idle", 32'(a_busy), 32'd0);

    // Test 2: simultaneous requests after reset alternate, starting at port 0.
    do_reset();
    req0_valid = 1'b1; req0_address = 32'h200;
    req1_valid = 1'b1; req1_address = 32'h300; req1_write_enable = 1'b0;
    expect_txn(0, 32'h200, 32'h0, 1'b0, 32'hA5A5_0200);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_idle_gap", 32'(a_busy), 32'd0);
    expect_txn(1, 32'h300, 32'h0, 1'b0, 32'hA5A5_0300);
    req0_valid = 1'b1; req0_address = 32'h204;
    req1_address = 32'h304;
    @(negedge clk);
    expect_txn(0, 32'h204, 32'h0, 1'b0, 32'hA5A5_0204);
    req0_valid = 1'b0;
    @(negedge clk);
    expect_txn(1, 32'h304, 32'h0, 1'b0, 32'hA5A5_0304);
    req1_valid = 1'b0;
    @(negedge clk);

    // Test 3: port 1 write; its read data keeps the earlier value.
    req1_valid = 1'b1; req1_address = 32'h204; req1_write_data = 32'h1234_5678; req1_write_enable = 1'b1;
    expect_txn(1, 32'h204, 32'h1234_5678, 1'b1, 32'hA5A5_0304);
    req1_valid = 1'b0; req1_write_enable = 1'b0;
    @(negedge clk);

    // Test 4: port 0 streams reads; port 1 raises valid during port 0's BUSY.
    req0_valid = 1'b1; req0_address = 32'h10;
    mid_raise = 1'b1; mid_addr = 32'h40;
    expect_txn(0, 32'h10, 32'h0, 1'b0, 32'hA5A5_0010);
    req0_address = 32'h14;
    @(negedge clk);
    expect_txn(1, 32'h40, 32'h0, 1'b0, 32'hA5A5_0040);
    req1_valid = 1'b0;
    @(negedge clk);
    expect_txn(0, 32'h14, 32'h0, 1'b0, 32'hA5A5_0014);
    req0_valid = 1'b0;
    @(negedge clk);

    // Test 5: reset during BUSY of a port 0 write.
    req0_valid = 1'b1; req0_address = 32'h300; req0_write_data = 32'hCAFE_F00D; req0_write_enable = 1'b1;
    @(negedge clk);
    check_eq("t5_we_first", 32'(a_mem_write_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_addr", a_mem_address, 32'h0);
    check_eq("t5_wdata", a_mem_write_data, 32'h0);
    check_eq("t5_we", 32'(a_mem_write_enable), 32'd0);
    check_eq("t5_busy", 32'(a_busy), 32'd0);
    check_eq("t5_rd", a_req0_read_data | a_req1_read_data, 32'h0);
    reset = 1'b0; req0_valid = 1'b0; req0_write_enable = 1'b0;
    seen = a_req0_ready;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | a_req0_ready;
    end
    check_eq("t5_no_ready", 32'(seen), 32'd0);
    req1_valid = 1'b1; req1_address = 32'h208;
    expect_txn(1, 32'h208, 32'h0, 1'b0, 32'hA5A5_0208);
    req1_valid = 1'b0;

    // Test 6: MEM_LATENCY=1 instance, port 0 holds valid for three reads.
    do_reset();
    req0_valid = 1'b1; req0_address = 32'h50; req0_write_enable = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check_eq("t6_busy", 32'(b_busy), (i % 3 != 0) ? 32'd1 : 32'd0);
      check_eq("t6_ready0", 32'(b_req0_ready), (i % 3 == 2) ? 32'd1 : 32'd0);
      check_eq("t6_ready1", 32'(b_req1_ready), 32'd0);
      if (i % 3 == 2) check_eq("t6_rd", b_req0_read_data, 32'hA5A5_0050);
      if (i == 8) req0_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
